// File: rtl/seq_detect_param.sv
// seq_detect_param: parameterised serial pattern detector with a saturating match counter.
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous, active-low reset
//   din        - serial data bit, MSB of the pattern arrives first
//   din_valid  - din is accepted on an edge only when high
//   overlap_en - 1 = matches may share bits, 0 = each match needs PAT_LEN fresh bits
//   load       - pattern load strobe, clears the window; has priority over din_valid
//   pattern    - new pattern, sampled when load=1
//   clr_cnt    - synchronous clear of match_cnt, wins over a coincident detection
//   match      - registered one-cycle detect pulse
//   match_cnt  - saturating detection count
//   fill       - accepted bits in the current window, saturating at PAT_LEN
module seq_detect_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] RST_PAT = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               din,
    input  logic                               din_valid,
    input  logic                               overlap_en,
    input  logic                               load,
    input  logic [PAT_LEN-1:0]                 pattern,
    input  logic                               clr_cnt,
    output logic                               match,
    output logic [CNT_W-1:0]                   match_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0]       fill
);
    localparam int             FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("seq_detect_param: PAT_LEN must be 2..16 and CNT_W 1..32");
    end

    logic [PAT_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_sh;
    logic [FW-1:0]      fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d, accept, det;

    // A load edge swallows din, so only non-load valid edges shift the window.
    assign accept   = din_valid && !load;
    assign hist_sh  = {hist_q[PAT_LEN-2:0], din};
    assign fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    // Detection looks at the post-update window so match lands one cycle after the last bit.
    assign det      = accept && (hist_sh == pat_q) && (fill_inc == FULL);

    always_comb begin
        pat_d   = load ? pattern : pat_q;
        hist_d  = load ? '0 : (accept ? hist_sh : hist_q);
        fill_d  = load ? '0 : (accept ? ((det && !overlap_en) ? '0 : fill_inc) : fill_q);
        match_d = det;
        cnt_d   = clr_cnt ? '0 : ((det && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q   <= RST_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign fill      = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: randomized and directed scoreboard bench for seq_detect_param (8-bit and 2-bit counters).
module tb_seq_detect_param;
    localparam int L = 3;

    logic clk = 1'b0;
    logic reset, din, din_valid, overlap_en, load, clr_cnt;
    logic [L-1:0] pattern;
    logic match_a, match_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b, fill_a, fill_b;

    always #5 clk = ~clk;

    seq_detect_param dut_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
        .load(load), .pattern(pattern), .clr_cnt(clr_cnt),
        .match(match_a), .match_cnt(cnt_a), .fill(fill_a)
    );

    seq_detect_param #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
        .load(load), .pattern(pattern), .clr_cnt(clr_cnt),
        .match(match_b), .match_cnt(cnt_b), .fill(fill_b)
    );

    typedef struct packed {
        logic       m;
        logic [1:0] f;
        logic [7:0] ca;
        logic [1:0] cb;
    } exp_t;

    exp_t sb[$];
    int vecs = 0, errs = 0;

    // Reference model: the window is the list of accepted bits since the last clear.
    bit         win[$];
    logic [L-1:0] m_pat;
    int         m_ca, m_cb;
    bit         m_match;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("match_a", 32'(match_a), 32'(e.m));
            chk("match_b", 32'(match_b), 32'(e.m));
            chk("fill_a", 32'(fill_a), 32'(e.f));
            chk("fill_b", 32'(fill_b), 32'(e.f));
            chk("cnt_a", 32'(cnt_a), 32'(e.ca));
            chk("cnt_b", 32'(cnt_b), 32'(e.cb));
        end
    end

    task automatic step(input bit r, input bit v, input bit d, input bit ov,
                        input bit ld, input logic [L-1:0] p, input bit clr);
        exp_t e;
        bit det;
        reset = r; din_valid = v; din = d; overlap_en = ov; load = ld; pattern = p; clr_cnt = clr;
        @(posedge clk);
        det = 1'b0;
        if (!r) begin
            win.delete();
            m_pat = 3'b101; m_ca = 0; m_cb = 0; m_match = 1'b0;
        end else begin
            if (ld) begin
                m_pat = p;
                win.delete();
            end else if (v) begin
                win.push_back(d);
                if (win.size() > L) void'(win.pop_front());
                if (win.size() == L) begin
                    det = 1'b1;
                    for (int i = 0; i < L; i++) if (win[i] != m_pat[L-1-i]) det = 1'b0;
                end
                if (det && !ov) win.delete();
            end
            m_match = det;
            if (clr) begin
                m_ca = 0; m_cb = 0;
            end else if (det) begin
                if (m_ca < 255) m_ca++;
                if (m_cb < 3) m_cb++;
            end
        end
        e.m = m_match; e.f = 2'(win.size()); e.ca = 8'(m_ca); e.cb = 2'(m_cb);
        sb.push_back(e);
        #1;
    endtask

    task automatic bits(input logic [15:0] s, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1, 1, s[i], ov, 0, 3'b000, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 1'b1, i[0], 0, 3'b000, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1'b1, 1, 1, 3'b111, 1);
    endtask

    initial begin
        reset = 1'b0; din = 1'b0; din_valid = 1'b0; overlap_en = 1'b0;
        load = 1'b0; pattern = '0; clr_cnt = 1'b0;
        do_reset(2);
        bits(16'b10101, 5, 1);
        idle(1);
        do_reset(1);
        bits(16'b10101, 5, 0);
        idle(1);
        step(1, 0, 0, 1, 1, 3'b110, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, (i < 2), 1, 0, 3'b000, 0);
            idle(2);
        end
        do_reset(1);
        bits(16'b101010101, 9, 1);
        bits(16'b0, 1, 1);
        step(1, 1, 1, 1, 0, 3'b000, 1);
        idle(1);
        do_reset(1);
        bits(16'b10, 2, 1);
        do_reset(1);
        bits(16'b1, 1, 1);
        idle(1);
        step(1, 1, 1, 1, 1, 3'b011, 0);
        bits(16'b011, 3, 1);
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0, 1'(($urandom_range(0, 1))),
                 1'(($urandom_range(0, 1))), $urandom_range(0, 59) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 49) == 0);
        end
        idle(1);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits; legal range 2..16.
REQ-002 Parameter RST_PAT, default 3'b101: pattern loaded at reset; width PAT_LEN.
REQ-003 Parameter CNT_W, default 8: match counter width; legal range 1..32.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 din  input  1  serial data bit.
REQ-007 din_valid  input  1  din is accepted on a rising edge only when this is high.
REQ-008 overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping detection.
REQ-009 load  input  1  pattern load strobe.
REQ-010 pattern  input  PAT_LEN  new pattern, sampled when load=1.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 match  output  1  registered Moore detect flag.
REQ-013 match_cnt  output  CNT_W  saturating count of detections.
REQ-014 fill  output  $clog2(PAT_LEN+1)  number of accepted bits in the current window, saturating at PAT_LEN.

Function
REQ-015 The block SHALL hold a pattern register pat_r, a history shift register hist, fill, match and match_cnt.
REQ-016 Bit order SHALL be MSB-first: the earliest accepted bit of a sequence is compared against pat_r[PAT_LEN-1], and the latest against pat_r[0].
REQ-017 An accepted bit SHALL update hist as hist <= {hist[PAT_LEN-2:0], din} and increment fill, saturating at PAT_LEN.
REQ-018 A detection event SHALL occur on an accepting edge when the updated hist equals pat_r and the updated fill equals PAT_LEN.
REQ-019 match SHALL be high for exactly the one cycle following the edge of a detection event, and low otherwise.
REQ-020 There SHALL be no combinational path from din to match.
REQ-021 With overlap_en=1, fill SHALL remain at PAT_LEN after a detection, so the next match can share bits with the previous one.
REQ-022 With overlap_en=0, fill SHALL be set to 0 on a detection edge, so the next match requires PAT_LEN fresh accepted bits.
REQ-023 overlap_en SHALL be sampled on each accepting edge and SHALL have no effect on an edge with no accepted bit.
REQ-024 Cycles with din_valid=0 SHALL leave hist and fill unchanged and SHALL drive match=0.
REQ-025 When load=1: pat_r <= pattern, hist <= 0, fill <= 0 and match <= 0; din is ignored on that edge; match_cnt is unchanged.
REQ-026 If load and din_valid are high on the same edge, load SHALL take priority.
REQ-027 A detection event SHALL increment match_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-028 clr_cnt=1 SHALL set match_cnt to 0; if it coincides with a detection event, the clear SHALL win and match SHALL still assert.
REQ-029 match_cnt SHALL count detections only and SHALL NOT change due to load.

Reset
REQ-030 While reset=0 at a rising edge: pat_r <= RST_PAT, hist <= 0, fill <= 0, match <= 0, match_cnt <= 0.
REQ-031 Reset SHALL override load, din_valid and clr_cnt.
REQ-032 Reset asserted mid-sequence SHALL discard the partial match; detection restarts from fill=0 on the first edge after reset=1.

Verification
REQ-033 Defaults, overlap_en=1, valid stream 1,0,1,0,1 -> match pulses after bits 3 and 5; match_cnt=2.
REQ-034 Defaults, overlap_en=0, stream 1,0,1,0,1 -> single match after bit 3; match_cnt=1; fill=2 at end.
REQ-035 load with pattern=3'b110, then stream 1,1,0 with din_valid low for 2 cycles between each bit -> single match after final bit; hist and fill unchanged during the gaps.
REQ-036 CNT_W=2, overlap_en=1, stream 1,0,1,0,1,0,1,0,1 -> match_cnt saturates at 3; clr_cnt coincident with a match gives match=1 and match_cnt=0.
REQ-037 Stream 1,0, then reset=0 for 1 cycle, then 1 -> no match; fill=1; all outputs zero during reset.
REQ-038 load and din_valid=1 on the same edge -> din ignored; fill=0; new pat_r active.
